// File: rtl/fp_add_issue_ctrl.sv
// Operand issue / result collection stage around an external pipelined FP32 adder.
// Latency: out_valid rises after edge k+2+ADD_LAT for a handshake on edge k; one op/cycle.
// Backpressure: credit (OUT_DEPTH - out_count - inflight) gates issue, so no result is ever dropped.
// Optional build macro FPADD_ISSUE_STATS_EN adds issue_cnt/stall_cnt saturating counters.

// Generic FIFO: registered storage, count register of width clog2(DEPTH)+1.
// Latency: data visible at pop_dat_o the cycle after the push edge.
// Backpressure: caller watches count_o; push when full and pop when empty are ignored.
module fp_add_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               pop_dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push_i && !full;
    assign do_pop    = pop_i && !empty;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, wrapping pointers and occupancy count; push+pop together keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module fp_add_issue_ctrl #(
    parameter int DEPTH     = 4,
    parameter int OUT_DEPTH = 4,
    parameter int ADD_LAT   = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef FPADD_ISSUE_STATS_EN
    ,
    output logic [15:0]      issue_cnt,
    output logic [15:0]      stall_cnt
`endif
);
    localparam int IW  = 64 + TAG_W;
    localparam int OW  = 32 + TAG_W;
    localparam int ICW = $clog2(DEPTH) + 1;
    localparam int OCW = $clog2(OUT_DEPTH) + 1;
    localparam int UW  = $clog2(OUT_DEPTH + ADD_LAT + 2) + 1;

    // Input FIFO
    logic [IW-1:0]    in_head;
    logic [ICW-1:0]   in_count;
    logic             in_push;
    logic             in_empty;
    logic [31:0]      hd_a;
    logic [31:0]      hd_b;
    logic [TAG_W-1:0] hd_tag;

    // Output FIFO
    logic [OW-1:0]    out_head;
    logic [OCW-1:0]   out_count;
    logic             out_push;
    logic             out_pop;

    // Issue / delay line
    logic             issue;
    logic             credit_ok;
    logic [UW-1:0]    inflight;
    logic [UW-1:0]    used;
    logic [ADD_LAT:0] vld_q;
    logic [ADD_LAT:0] vld_d;
    logic [TAG_W-1:0] tag_q [ADD_LAT+1];
    logic [TAG_W-1:0] tag_d [ADD_LAT+1];
    logic [31:0]      add_a_q;
    logic [31:0]      add_a_d;
    logic [31:0]      add_b_q;
    logic [31:0]      add_b_d;

    // in_ready depends only on registered occupancy, never on in_valid or out_ready.
    assign in_ready = (in_count != ICW'(DEPTH));
    assign in_empty = (in_count == '0);
    assign in_push  = in_valid && in_ready;
    assign hd_a     = in_head[IW-1 -: 32];
    assign hd_b     = in_head[TAG_W +: 32];
    assign hd_tag   = in_head[TAG_W-1:0];

    fp_add_issue_fifo #(
        .W     (IW),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (in_push),
        .push_dat_i ({in_a, in_b, in_tag}),
        .pop_i      (issue),
        .pop_dat_o  (in_head),
        .count_o    (in_count)
    );

    // Credit: a result landing in the output FIFO this edge is still counted in inflight,
    // and becomes out_count next cycle, so every op is counted exactly once.
    always_comb begin
        inflight = '0;
        for (int k = 0; k <= ADD_LAT; k++) begin
            inflight = inflight + UW'(vld_q[k]);
        end
        used      = UW'(out_count) + inflight;
        credit_ok = (used < UW'(OUT_DEPTH));
        issue     = !in_empty && credit_ok;
    end

    // Next state for the adder operand registers and the valid/tag delay line.
    always_comb begin
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        vld_d    = '0;
        tag_d[0] = tag_q[0];
        if (issue) begin
            add_a_d  = hd_a;
            add_b_d  = hd_b;
            tag_d[0] = hd_tag;
        end
        vld_d[0] = issue;
        for (int k = 1; k <= ADD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            tag_d[k] = tag_q[k-1];
        end
    end

    // Operand and delay-line registers; reset drops every in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q <= '0;
            add_b_q <= '0;
            vld_q   <= '0;
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            vld_q   <= vld_d;
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign add_a = add_a_q;
    assign add_b = add_b_q;

    // The last delay-line stage lines up with add_s; credit guarantees room.
    assign out_push  = vld_q[ADD_LAT];
    assign out_valid = (out_count != '0);
    assign out_pop   = out_valid && out_ready;
    assign out_sum   = out_head[OW-1 -: 32];
    assign out_tag   = out_head[TAG_W-1:0];

    fp_add_issue_fifo #(
        .W     (OW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (out_push),
        .push_dat_i ({add_s, tag_q[ADD_LAT]}),
        .pop_i      (out_pop),
        .pop_dat_o  (out_head),
        .count_o    (out_count)
    );

    assign busy = !in_empty || (|vld_q) || out_valid;

`ifdef FPADD_ISSUE_STATS_EN
    logic [15:0] issue_cnt_q;
    logic [15:0] issue_cnt_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Saturating counters: ops issued, and cycles with work waiting but no credit.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (issue && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        if (!in_empty && !credit_ok && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule
